// File: rtl/instruction_fetch.sv
// IF stage: PC register, word-organised instruction memory loaded while idle,
// and the IF/ID pipeline register with jump flush, stall, freeze and HALT stop.
module instruction_fetch #(
  parameter int          NB_DATA     = 32,
  parameter int          NB_MEM_ADDR = 8,
  parameter logic [31:0] HALT_WORD   = 32'hFFFFFFFF,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_en,
  input  logic [NB_MEM_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0]     i_load_data,
  input  logic                   i_run,
  input  logic                   i_jump,
  input  logic [NB_DATA-1:0]     i_addr2jump,
  input  logic                   i_stall,
  input  logic                   i_halt,
  output logic [NB_DATA-1:0]     o_instruction,
  output logic [NB_DATA-1:0]     o_pcounter4,
  output logic [NB_DATA-1:0]     o_pc,
  output logic                   o_valid,
  output logic                   o_halted
);

  localparam int MEM_DEPTH = 2 ** NB_MEM_ADDR;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [NB_DATA-1:0]     r_mem [0:MEM_DEPTH-1];
  logic [1:0]             r_state;
  logic [NB_DATA-1:0]     r_pc;
  logic [NB_DATA-1:0]     r_instruction;
  logic [NB_DATA-1:0]     r_pcounter4;
  logic                   r_valid;
  logic                   r_halted;

  logic [NB_MEM_ADDR-1:0] w_rd_idx;
  logic [NB_DATA-1:0]     w_fetch;
  logic [NB_DATA-1:0]     w_pc_plus4;
  logic [NB_DATA-1:0]     w_jump_target;
  logic                   w_is_halt;

  // PC bits above the memory index are ignored, so fetches wrap modulo depth.
  assign w_rd_idx      = r_pc[NB_MEM_ADDR+1:2];
  assign w_fetch       = r_mem[w_rd_idx];
  assign w_pc_plus4    = r_pc + NB_DATA'(4);
  assign w_jump_target = i_addr2jump & ~NB_DATA'(3);
  assign w_is_halt     = (w_fetch == NB_DATA'(HALT_WORD));

  // Program loading is only possible while idle; memory survives reset.
  always_ff @(posedge clk) begin
    if (i_rst_n && (r_state == ST_IDLE) && i_load_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_instruction <= NB_DATA'(NOP_WORD);
      r_pcounter4   <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc          <= '0;
          r_instruction <= NB_DATA'(NOP_WORD);
          r_pcounter4   <= '0;
          r_valid       <= 1'b0;
          if (i_run) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Freeze beats stall beats jump; a stalled jump is re-presented by decode.
          if (i_halt || i_stall) begin
            r_state <= ST_RUN;
          end else if (i_jump) begin
            r_pc          <= w_jump_target;
            r_instruction <= NB_DATA'(NOP_WORD);
            r_valid       <= 1'b0;
          end else begin
            r_instruction <= w_fetch;
            r_pcounter4   <= w_pc_plus4;
            r_valid       <= 1'b1;
            if (w_is_halt) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        ST_HALTED: begin
          if (!i_halt) begin
            r_instruction <= NB_DATA'(NOP_WORD);
            r_valid       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_instruction = r_instruction;
  assign o_pcounter4   = r_pcounter4;
  assign o_pc          = r_pc;
  assign o_valid       = r_valid;
  assign o_halted      = r_halted;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of instruction_decode. It holds the PC and a word-organised instruction memory, loaded over a debug write port before execution. It presents the IF/ID pipeline register (o_instruction, o_pcounter4) to decode and applies decode's jump redirect, hazard stall, external freeze and HALT detection.

Parameters:
NB_DATA, 32, instruction/PC width
NB_MEM_ADDR, 8, instruction-memory word-address width (depth = 2**NB_MEM_ADDR words)
HALT_WORD, 32'hFFFFFFFF, end-of-program encoding
NOP_WORD, 32'h00000000, bubble injected on flush/idle/halted

Ports:
clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_load_en  in  1  instruction-memory write strobe (accepted in IDLE only)
i_load_addr  in  NB_MEM_ADDR  word address for load
i_load_data  in  NB_DATA  instruction word to store
i_run  in  1  start execution from PC=0 (accepted in IDLE only)
i_jump  in  1  redirect request from decode
i_addr2jump  in  NB_DATA  redirect target byte address
i_stall  in  1  load-use hazard stall: hold PC and IF/ID
i_halt  in  1  external freeze (debug step control): hold all state
o_instruction  out  NB_DATA  IF/ID instruction register
o_pcounter4  out  NB_DATA  IF/ID PC+4 of o_instruction
o_pc  out  NB_DATA  current fetch PC
o_valid  out  1  o_instruction holds a fetched (non-bubble) word
o_halted  out  1  HALT_WORD has been fetched; fetch stopped

Behaviour:
- Reset (i_rst_n=0 at posedge, synchronous): state=IDLE, PC=0, o_instruction=NOP_WORD, o_pcounter4=0, o_valid=0, o_halted=0. Memory contents NOT cleared; reset mid-run returns to IDLE with memory preserved.
- Memory: 2**NB_MEM_ADDR x NB_DATA, synchronous write, read index = PC[NB_MEM_ADDR+1:2]; PC beyond depth wraps modulo depth.
- FSM states: IDLE, RUN, HALTED.
- IDLE: i_load_en writes mem[i_load_addr]<=i_load_data. IF/ID holds NOP, o_valid=0, PC=0. i_run=1 -> RUN next cycle (if i_load_en and i_run coincide, write completes, then RUN). i_jump/i_stall ignored.
- RUN, priority per cycle: i_halt > i_stall > i_jump > normal.
  - i_halt=1: every register (PC, IF/ID, state) holds.
  - i_stall=1: PC and IF/ID hold; i_jump ignored this cycle (decode re-evaluates next cycle).
  - i_jump=1: PC<={i_addr2jump[NB_DATA-1:2],2'b00}; o_instruction<=NOP_WORD, o_valid<=0 (wrong-path slot flushed, no delay slot); o_pcounter4 holds.
  - normal: o_instruction<=mem[PC], o_pcounter4<=PC+4, o_valid<=1, PC<=PC+4 (mod 2**NB_DATA).
  - if fetched word == HALT_WORD: it is still loaded into IF/ID (decode raises its stop), PC holds, state->HALTED, o_halted<=1 same edge.
- HALTED: PC frozen; next un-frozen edge loads NOP_WORD into IF/ID, o_valid=0 thereafter; i_jump, i_stall, i_run, i_load_en ignored; exit only via reset.
- i_load_en outside IDLE: ignored, memory unchanged.
- Latency: instruction at PC visible on o_instruction one cycle after PC is presented; jump target's instruction appears 2 cycles after the i_jump edge (1 bubble).
- o_pc is the PC register directly.

Test Plan:
- Load mem[0..3]={0x20010005,0x20020007,0x00221820,0xFFFFFFFF}, pulse i_run -> o_instruction sequence 0x20010005,0x20020007,0x00221820,0xFFFFFFFF with o_pcounter4 4,8,12,16; then o_halted=1, o_instruction=0, o_pc stays 12.
- RUN at PC=8, i_jump=1, i_addr2jump=0x00000022 -> PC=0x20, next o_instruction=NOP, o_valid=0, following cycle mem[8] with o_pcounter4=0x24.
- i_stall=1 for 2 cycles with i_jump=1 simultaneously -> PC, o_instruction, o_pcounter4 unchanged both cycles; jump not taken.
- i_halt=1 for 3 cycles mid-run -> all outputs frozen; release resumes exactly at next sequential PC.
- i_load_en=1 to addr 0 with data 0x12345678 during RUN -> mem[0] unchanged after reset+rerun.
- Reset mid-run at PC=0x10 -> next cycle PC=0, o_instruction=0, o_valid=0, IDLE; i_run replays previously loaded program unchanged.
